// File: rtl/bram_r_arbiter_pkg.sv
// Shared defaults and state type for the sample BRAM arbiter.
// Optional zero-fill sweep after reset: define SRP_BRAM_INIT_EN.
package srp_bram_pkg;

  localparam int AW           = 12;
  localparam int DW           = 32;
  localparam int DEPTH        = 2096;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bram_r_arbiter_if.sv
// Request, response and BRAM-side signals of the sample BRAM arbiter.
// slave = arbiter view, master = requester/BRAM view.
interface bram_r_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          rd_err;

  logic          busy;

  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr,
    input  bram_dout,
    output wr_ready, wr_err,
    output rd_ready, rd_rvalid, rd_rdata, rd_err,
    output busy,
    output bram_en, bram_we, bram_addr, bram_di
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr,
    output bram_dout,
    input  wr_ready, wr_err,
    input  rd_ready, rd_rvalid, rd_rdata, rd_err,
    input  busy,
    input  bram_en, bram_we, bram_addr, bram_di
  );

endinterface

// File: rtl/bram_r_arbiter_rd_pipe.sv
// Two-stage valid/err pipeline aligning read responses
// with the BRAM output one cycle after the registered enable.
module bram_r_rd_pipe #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic          req_err,
  input  logic [DW-1:0] dout,
  output logic          rvalid,
  output logic          rerr,
  output logic [DW-1:0] rdata
);

  logic s1_vld_q, s1_vld_d;
  logic s1_err_q, s1_err_d;
  logic s2_vld_q, s2_vld_d;
  logic s2_err_q, s2_err_d;

  always_comb begin
    s1_vld_d = req_vld;
    s1_err_d = req_vld & req_err;
    s2_vld_d = s1_vld_q;
    s2_err_d = s1_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
      s2_vld_q <= s2_vld_d;
      s2_err_q <= s2_err_d;
    end
  end

  // dropped reads never touched the BRAM, so their data is forced to 0
  assign rvalid = s2_vld_q;
  assign rerr   = s2_err_q;
  assign rdata  = (s2_vld_q && !s2_err_q) ? dout : '0;

endmodule

// File: rtl/bram_r_arbiter.sv
// Single-port sample BRAM arbiter: write-priority with read anti-starvation.
// SRP_BRAM_INIT_EN enables the zero-fill sweep after reset.
module bram_r_arbiter
  import srp_bram_pkg::*;
#(
  parameter int DEPTH_P        = DEPTH,
  parameter int AW_P           = AW,
  parameter int DW_P           = DW,
  parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  bram_r_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT_P + 1);

`ifdef SRP_BRAM_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t          state_q, state_d;
  logic [AW_P-1:0] init_addr_q, init_addr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            bram_en_q, bram_en_d;
  logic            bram_we_q, bram_we_d;
  logic [AW_P-1:0] bram_addr_q, bram_addr_d;
  logic [DW_P-1:0] bram_di_q, bram_di_d;
  logic            wr_err_q, wr_err_d;

  logic wr_gnt, rd_gnt, rd_force;
  logic wr_in, rd_in;

  assign wr_in = 32'(bus.wr_addr) < 32'(DEPTH_P);
  assign rd_in = 32'(bus.rd_addr) < 32'(DEPTH_P);

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    starve_d    = starve_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_di_d   = bram_di_q;
    wr_err_d    = 1'b0;
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    rd_force    = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        bram_en_d   = 1'b1;
        bram_we_d   = 1'b1;
        bram_addr_d = init_addr_q;
        bram_di_d   = '0;
        starve_d    = '0;
        if (init_addr_q == AW_P'(DEPTH_P - 1))
          state_d = ST_RUN;
        else
          init_addr_d = init_addr_q + AW_P'(1);
      end
      ST_RUN: begin
        rd_force = bus.rd_valid &&
                   (starve_q == SW'(STARVE_LIMIT_P));
        wr_gnt   = !rst && bus.wr_valid && !rd_force;
        rd_gnt   = !rst && bus.rd_valid && !wr_gnt;

        if (wr_gnt) begin
          wr_err_d = !wr_in;
          if (wr_in) begin
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b1;
            bram_addr_d = bus.wr_addr;
            bram_di_d   = bus.wr_data;
          end
        end else if (rd_gnt && rd_in) begin
          bram_en_d   = 1'b1;
          bram_addr_d = bus.rd_addr;
        end

        // counts writes that overtook a waiting read
        if (!bus.rd_valid || rd_gnt)
          starve_d = '0;
        else if (wr_gnt && starve_q != SW'(STARVE_LIMIT_P))
          starve_d = starve_q + SW'(1);
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      starve_q    <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      starve_q    <= starve_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q   <= bram_di_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.wr_ready  = wr_gnt;
  assign bus.rd_ready  = rd_gnt;
  assign bus.wr_err    = wr_err_q;
  assign bus.bram_en   = bram_en_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_di   = bram_di_q;

`ifdef SRP_BRAM_INIT_EN
  assign bus.busy = (state_q == ST_INIT);
`else
  assign bus.busy = 1'b0;
`endif

  bram_r_rd_pipe #(
    .DW (DW_P)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .req_vld (rd_gnt),
    .req_err (!rd_in),
    .dout    (bus.bram_dout),
    .rvalid  (bus.rd_rvalid),
    .rerr    (bus.rd_err),
    .rdata   (bus.rd_rdata)
  );

endmodule

// File: tb/tb_bram_r_arbiter.sv
// Bench for bram_r_arbiter: vector table, read scoreboard, corner sequences.
// Covers the SRP_BRAM_INIT_EN sweep when that macro is defined.
module tb_bram_r_arbiter;
  import srp_bram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_r_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  bram_r_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];

  // write-first single-port BRAM model
  always @(posedge clk) begin
    if (bif.bram_en) begin
      if (bif.bram_we) begin
        mem[bif.bram_addr] <= bif.bram_di;
        bif.bram_dout      <= bif.bram_di;
      end else begin
        bif.bram_dout <= mem[bif.bram_addr];
      end
    end
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rv_cnt   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: push on read grant, pop on response
  always @(negedge clk) begin
    if (bif.rd_rvalid) rv_cnt++;
    if (rst) begin
      sb.delete();
    end else begin
      if (bif.rd_rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rd_err", bif.rd_err, e.err);
          chk("rd_rdata", bif.rd_rdata, e.data);
          chk("rd_latency", 64'(cyc - e.cyc), 2);
        end
      end
      if (bif.rd_ready) begin
        e.err  = !(32'(bif.rd_addr) < DEPTH);
        e.data = e.err ? '0 : shadow[bif.rd_addr];
        e.cyc  = cyc;
        sb.push_back(e);
      end
      if (bif.wr_ready && 32'(bif.wr_addr) < DEPTH)
        shadow[bif.wr_addr] = bif.wr_data;
    end
  end

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic          ewr;
    logic          erd;
    logic          een;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edi;
    logic          ewerr;
  } vec_t;

  vec_t vt[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.wr_valid = 1'b0;
    bif.rd_valid = 1'b0;
  endtask

  task automatic wait_run();
`ifdef SRP_BRAM_INIT_EN
    int n = 0;
    while (bif.busy && n < 3000) begin
      step();
      n++;
    end
    if (bif.busy) chk("init_timeout", 1, 0);
`endif
  endtask

  initial begin
    int base;
    int bad;
    int n;

    for (int i = 0; i < DEPTH; i++) begin
`ifdef SRP_BRAM_INIT_EN
      mem[i] = 32'hFFFF_FFFF;
`else
      mem[i] = '0;
`endif
      shadow[i] = '0;
    end
    bif.bram_dout = '0;
    bif.wr_addr   = '0;
    bif.wr_data   = '0;
    bif.rd_addr   = '0;
    bif.wr_valid  = 1'b1;
    bif.rd_valid  = 1'b1;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", bif.wr_ready, 0);
    chk("rst_rd_ready", bif.rd_ready, 0);
    chk("rst_bram_en", bif.bram_en, 0);
    chk("rst_bram_we", bif.bram_we, 0);
    chk("rst_bram_addr", bif.bram_addr, 0);
    chk("rst_bram_di", bif.bram_di, 0);
    chk("rst_rd_rvalid", bif.rd_rvalid, 0);
    chk("rst_wr_err", bif.wr_err, 0);
`ifdef SRP_BRAM_INIT_EN
    chk("rst_busy", bif.busy, 1);
`else
    chk("rst_busy", bif.busy, 0);
`endif
    idle();
    step();
    rst = 1'b0;

`ifdef SRP_BRAM_INIT_EN
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (bif.busy && n < 3000) begin
      if (n > 0 && 32'(bif.bram_addr) != 32'(n - 1)) bad++;
      if (n > 0 && (!bif.bram_en || !bif.bram_we)) bad++;
      n++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 64'(n), 64'(DEPTH));
    chk("init_sweep_errors", 64'(bad), 0);
    step();
    bif.rd_valid = 1'b1;
    bif.rd_addr  = 12'd100;
    step();
    idle();
    repeat (4) step();
`endif

    vt[0] = '{1, 12'd5, 32'hDEADBEEF, 0, 12'd0,
              1, 0, 1, 1, 12'd5, 32'hDEADBEEF, 0};
    vt[1] = '{0, 12'd0, 32'h0, 1, 12'd5,
              0, 1, 1, 0, 12'd5, 32'hDEADBEEF, 0};
    vt[2] = '{1, 12'd6, 32'hA5A5A5A5, 1, 12'd7,
              1, 0, 1, 1, 12'd6, 32'hA5A5A5A5, 0};
    vt[3] = '{1, 12'd2096, 32'h11111111, 0, 12'd0,
              1, 0, 0, 0, 12'd6, 32'hA5A5A5A5, 1};
    vt[4] = '{0, 12'd0, 32'h0, 1, 12'd4095,
              0, 1, 0, 0, 12'd6, 32'hA5A5A5A5, 0};
    vt[5] = '{0, 12'd9, 32'h0, 0, 12'd9,
              0, 0, 0, 0, 12'd6, 32'hA5A5A5A5, 0};
    vt[6] = '{1, 12'd2095, 32'h0BADF00D, 0, 12'd0,
              1, 0, 1, 1, 12'd2095, 32'h0BADF00D, 0};
    vt[7] = '{0, 12'd0, 32'h0, 1, 12'd2095,
              0, 1, 1, 0, 12'd2095, 32'h0BADF00D, 0};
    vt[8] = '{1, 12'd0, 32'h12345678, 0, 12'd0,
              1, 0, 1, 1, 12'd0, 32'h12345678, 0};
    vt[9] = '{0, 12'd0, 32'h0, 1, 12'd0,
              0, 1, 1, 0, 12'd0, 32'h12345678, 0};

    for (int i = 0; i < 10; i++) begin
      step();
      bif.wr_valid = vt[i].wv;
      bif.wr_addr  = vt[i].wa;
      bif.wr_data  = vt[i].wd;
      bif.rd_valid = vt[i].rv;
      bif.rd_addr  = vt[i].ra;
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", i), bif.wr_ready, vt[i].ewr);
      chk($sformatf("v%0d_rd_ready", i), bif.rd_ready, vt[i].erd);
      step();
      idle();
      @(negedge clk);
      chk($sformatf("v%0d_bram_en", i), bif.bram_en, vt[i].een);
      chk($sformatf("v%0d_bram_we", i), bif.bram_we, vt[i].ewe);
      chk($sformatf("v%0d_bram_addr", i), bif.bram_addr, vt[i].eaddr);
      chk($sformatf("v%0d_bram_di", i), bif.bram_di, vt[i].edi);
      chk($sformatf("v%0d_wr_err", i), bif.wr_err, vt[i].ewerr);
    end
    repeat (3) step();

    // write then read same address on the next cycle: new data
    bif.wr_valid = 1'b1;
    bif.wr_addr  = 12'd5;
    bif.wr_data  = 32'hCAFEF00D;
    step();
    bif.wr_valid = 1'b0;
    bif.rd_valid = 1'b1;
    bif.rd_addr  = 12'd5;
    step();
    // read then write same address: read returns old data
    bif.rd_valid = 1'b0;
    bif.wr_valid = 1'b1;
    bif.wr_data  = 32'h0F0F0F0F;
    step();
    bif.rd_valid = 1'b1;
    bif.wr_valid = 1'b0;
    step();
    idle();
    repeat (4) step();
    chk("wr_rd_order_drained", 64'(sb.size()), 0);

    // continuous contention: 4 writes then 1 read
    bif.wr_valid = 1'b1;
    bif.wr_addr  = 12'd20;
    bif.wr_data  = 32'h55;
    bif.rd_valid = 1'b1;
    bif.rd_addr  = 12'd21;
    base = rv_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("starve_rd_%0d", i), bif.rd_ready, (i % 5) == 4);
      chk($sformatf("starve_wr_%0d", i), bif.wr_ready, (i % 5) != 4);
      step();
    end
    idle();
    repeat (3) step();
    chk("starve_rvalid_count", 64'(rv_cnt - base), 4);

    // back-to-back reads of 0..7
    for (int i = 0; i < 8; i++) begin
      bif.wr_valid = 1'b1;
      bif.wr_addr  = AW'(i);
      bif.wr_data  = 32'h1000 + 32'(i);
      step();
    end
    idle();
    base = rv_cnt;
    for (int i = 0; i < 8; i++) begin
      bif.rd_valid = 1'b1;
      bif.rd_addr  = AW'(i);
      step();
    end
    idle();
    repeat (4) step();
    chk("b2b_rvalid_count", 64'(rv_cnt - base), 8);

    // reset one cycle after a read grant
    bif.rd_valid = 1'b1;
    bif.rd_addr  = 12'd3;
    base = rv_cnt;
    step();
    bif.rd_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_run();
    repeat (4) step();
    chk("rst_discard_rvalid", 64'(rv_cnt - base), 0);

    bif.wr_valid = 1'b1;
    bif.wr_addr  = 12'd30;
    bif.wr_data  = 32'h77;
    bif.rd_valid = 1'b1;
    bif.rd_addr  = 12'd31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rd_%0d", i), bif.rd_ready, i == 4);
      step();
    end
    idle();

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    chk("final_drain", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_r_arbiter.md
Name: bram_r_arbiter

Overview:
Arbitrates the single-port 2096x32 sample BRAM between two requesters of the Shapiro-Rudin-Park time synchronizer:
- a write requester (the sample-capture stream);
- a read requester (the correlator fetch).

The block registers all BRAM controls, returns read data with a valid strobe, range-checks addresses and limits read starvation. It sits between the capture/correlator logic and the BRAM primitive.

Parameters:
DEPTH, 2096, number of BRAM words; legal addresses are 0..DEPTH-1
AW, 12, address width
DW, 32, data width
STARVE_LIMIT, 4, maximum consecutive write grants while a read is pending before the read is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle (combinational)
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped
rd_valid  in  1  read request
rd_ready  out  1  read accepted this cycle (combinational)
rd_addr  in  AW  read address
rd_rvalid  out  1  read data valid
rd_rdata  out  DW  read data
rd_err  out  1  qualifies rd_rvalid: address was out of range, rd_rdata=0
busy  out  1  high while in INIT
bram_en  out  1  BRAM enable (registered)
bram_we  out  1  BRAM write enable (registered)
bram_addr  out  AW  BRAM address (registered)
bram_di  out  DW  BRAM write data (registered)
bram_dout  in  DW  BRAM read data; valid one cycle after bram_en with bram_we=0

Behaviour:
- Clock and reset: already decided — one clock, clk; rst is synchronous and active-high.
- Reset values: all outputs 0; starve_cnt=0; state=INIT if SRP_BRAM_INIT_EN is defined, otherwise RUN.
- States:
  - INIT: zero-fill sweep. wr_ready=rd_ready=0, busy=1.
  - RUN: normal arbitration.
- Arbitration in RUN (cycle N):
  - Only wr_valid: write granted.
  - Only rd_valid: read granted.
  - Both valid: write wins, unless starve_cnt==STARVE_LIMIT, in which case read wins.
  - At most one grant per cycle; ready is high only for the granted requester.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each write grant while rd_valid=1.
  - Clears on any read grant, or on any cycle with rd_valid=0.
- Grant at edge N -> BRAM controls driven during cycle N+1:
  - bram_en=1; bram_we=1 for a write, 0 for a read.
  - Idle cycle: bram_en=0, bram_we=0; bram_addr/bram_di hold their previous values.
- Read latency: rd_rvalid is asserted at cycle N+2, with rd_rdata=bram_dout. Sustained throughput is one read per cycle. There is no response backpressure; the reader must sink every response.
- Out-of-range requests (addr >= DEPTH):
  - Handshake still completes; bram_en stays 0.
  - Write: wr_err pulses at N+1.
  - Read: at N+2, rd_rvalid=1, rd_err=1, rd_rdata=0.
  - addr 2096..4095 are all out of range.
- Same-address ordering:
  - Write granted at N, read granted at N+1 or later: the read returns the new data (BRAM is write-first, ordering is preserved).
  - Read granted at N, write granted at N+1: the read returns the old data.
- Reset in RUN: in-flight reads are discarded; rd_rvalid=0 from the cycle after rst is sampled.

Optional Feature:
SRP_BRAM_INIT_EN
- Defined: after reset, state=INIT.
  - Writes 0 to addresses 0..DEPTH-1, one per cycle, DEPTH cycles total, using bram_en=1, bram_we=1, bram_di=0.
  - Then enters RUN and drops busy.
  - rst during INIT restarts the sweep at address 0.
- Undefined: the block enters RUN directly after reset; busy is tied to 0.

Decomposition:
- Package srp_bram_pkg holds AW, DW and DEPTH defaults plus the state enum (INIT, RUN).
- One natural sub-module: bram_r_rd_pipe, a 2-stage valid/err shift pipeline that aligns rd_rvalid/rd_err with bram_dout.

Test Plan:
1. Init: with SRP_BRAM_INIT_EN, release rst -> busy high for exactly 2096 cycles, bram_addr steps 0..2095, then read addr 100 -> rd_rdata=0.
2. Write then read: write 0xDEADBEEF at addr 5 (cycle N), read addr 5 at N+1 -> rd_rvalid at N+3 with 0xDEADBEEF.
3. Starvation: hold wr_valid and rd_valid high continuously -> grant pattern is 4 writes, 1 read, repeating; rd_rvalid appears every 5 cycles.
4. Out of range: write addr 2096 -> wr_err pulse, bram_en stays 0; read addr 4095 -> rd_rvalid=1, rd_err=1, rd_rdata=0.
5. Back-to-back reads of addr 0..7 -> 8 consecutive rd_rvalid cycles, data in order, 2-cycle latency.
6. Reset mid-stream: assert rst one cycle after a read grant -> no rd_rvalid is produced; after reset, arbitration resumes with starve_cnt=0.
